// File: rtl/hazard_pkg.sv
`default_nettype none
// hazard_pkg: slot record, multi-cycle unit state encoding and shared constants.
package hazard_pkg;

    localparam int MAX_REG_AW = 8;
    localparam logic [MAX_REG_AW-1:0] REG_ZERO = '0;

    // Register fields are stored at MAX_REG_AW and zero-extended from REG_AW.
    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
        logic                  is_long;
        logic [MAX_REG_AW-1:0] rs1;
        logic [MAX_REG_AW-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
    } slot_t;

    localparam slot_t BUBBLE = '0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lu_state_e;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// fwd_select: picks the youngest post-decode slot (k >= 2) whose result can be
// forwarded to a slot-1 operand; sel = k-1, or 0 for the register file.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int PIPE_DEPTH      = 3,
    parameter int REG_AW          = 5,
    parameter int LOAD_READY_SLOT = 3,
    parameter int SEL_W           = $clog2(PIPE_DEPTH)
) (
    input  logic [REG_AW-1:0]            rs_i,
    input  logic [PIPE_DEPTH-1:0]        valid_i,
    input  logic [PIPE_DEPTH-1:0]        reg_write_i,
    input  logic [PIPE_DEPTH-1:0]        is_load_i,
    input  logic [PIPE_DEPTH*REG_AW-1:0] rd_i,
    output logic [SEL_W-1:0]             sel_o
);

    logic [PIPE_DEPTH-1:0] w_match;

    assign w_match[0] = 1'b0;

    for (genvar k = 2; k <= PIPE_DEPTH; k++) begin : g_match
        localparam bit LOAD_TOO_EARLY = (k < LOAD_READY_SLOT);
        logic [REG_AW-1:0] w_rd;
        assign w_rd = rd_i[(k-1)*REG_AW +: REG_AW];
        assign w_match[k-1] = valid_i[k-1] && reg_write_i[k-1]
                              && (w_rd != REG_ZERO[REG_AW-1:0]) && (w_rd == rs_i)
                              && !(is_load_i[k-1] && LOAD_TOO_EARLY);
    end

    // Scan oldest to youngest so the nearest producer overwrites the choice.
    always_comb begin
        sel_o = '0;
        for (int k = PIPE_DEPTH; k >= 2; k--) begin
            if (w_match[k-1]) begin
                sel_o = SEL_W'(k - 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// hazard_scoreboard: shadow-pipeline hazard unit (load-use, forwarding, redirect,
// multi-cycle stall). Define HAZARD_PERF_EN to build the stall/flush counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int PIPE_DEPTH      = 3,
    parameter int REG_AW          = 5,
    parameter int LOAD_READY_SLOT = 3,
    parameter int SEL_W           = $clog2(PIPE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_use_rs1,
    input  logic              d_use_rs2,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_reg_write,
    input  logic              d_is_load,
    input  logic              d_is_long,
    input  logic              e_redirect,
    input  logic              lu_done,
    output logic              pc_en,
    output logic              f_d_en,
    output logic              d_e_en,
    output logic              f_d_flush,
    output logic              d_e_flush,
    output logic              lu_start,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
);

    slot_t     slot_q [1:PIPE_DEPTH];
    slot_t     slot_d [1:PIPE_DEPTH];
    lu_state_e state_q, state_d;

    slot_t w_dec;
    logic  w_start;
    logic  w_freeze;
    logic  w_redirect;
    logic  w_load_use;

    always_comb begin
        w_dec = BUBBLE;
        if (d_valid) begin
            w_dec.valid     = 1'b1;
            w_dec.rd        = MAX_REG_AW'(d_rd);
            w_dec.reg_write = d_reg_write;
            w_dec.is_load   = d_is_load;
            w_dec.is_long   = d_is_long;
            w_dec.rs1       = MAX_REG_AW'(d_rs1);
            w_dec.rs2       = MAX_REG_AW'(d_rs2);
            w_dec.use_rs1   = d_use_rs1;
            w_dec.use_rs2   = d_use_rs2;
        end
    end

    // A load in slot j is still too young for the decode consumer while j+1 < LOAD_READY_SLOT.
    always_comb begin
        w_load_use = 1'b0;
        for (int j = 1; j <= PIPE_DEPTH; j++) begin
            if ((j + 1 < LOAD_READY_SLOT) && slot_q[j].valid && slot_q[j].is_load
                && (slot_q[j].rd != REG_ZERO)
                && ((w_dec.use_rs1 && (slot_q[j].rd == w_dec.rs1))
                    || (w_dec.use_rs2 && (slot_q[j].rd == w_dec.rs2)))) begin
                w_load_use = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        w_start  = 1'b0;
        w_freeze = 1'b0;
        case (state_q)
            IDLE: begin
                if (slot_q[1].valid && slot_q[1].is_long) begin
                    w_start = 1'b1;
                    if (!lu_done) begin
                        state_d  = BUSY;
                        w_freeze = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (lu_done) begin
                    state_d = IDLE;
                end else begin
                    w_freeze = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign lu_start   = w_start;
    assign w_redirect = e_redirect && slot_q[1].valid && !slot_q[1].is_long && !w_freeze;

    always_comb begin
        pc_en     = 1'b1;
        f_d_en    = 1'b1;
        d_e_en    = 1'b1;
        f_d_flush = 1'b0;
        d_e_flush = 1'b0;
        if (w_freeze) begin
            pc_en  = 1'b0;
            f_d_en = 1'b0;
            d_e_en = 1'b0;
        end else if (w_redirect) begin
            f_d_flush = 1'b1;
            d_e_flush = 1'b1;
        end else if (w_load_use) begin
            pc_en     = 1'b0;
            f_d_en    = 1'b0;
            d_e_flush = 1'b1;
        end
    end

    // Older slots always drain; a freeze holds slot 1 and injects a bubble behind it.
    always_comb begin
        slot_d = slot_q;
        for (int k = PIPE_DEPTH; k >= 3; k--) begin
            slot_d[k] = slot_q[k-1];
        end
        if (w_freeze) begin
            slot_d[2] = BUBBLE;
        end else begin
            slot_d[2] = slot_q[1];
            slot_d[1] = (d_e_en && !d_e_flush) ? w_dec : BUBBLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                slot_q[k] <= BUBBLE;
            end
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    logic [PIPE_DEPTH-1:0]        w_slot_valid;
    logic [PIPE_DEPTH-1:0]        w_slot_wr;
    logic [PIPE_DEPTH-1:0]        w_slot_ld;
    logic [PIPE_DEPTH*REG_AW-1:0] w_slot_rd;

    for (genvar k = 1; k <= PIPE_DEPTH; k++) begin : g_flat
        assign w_slot_valid[k-1]                  = slot_q[k].valid;
        assign w_slot_wr[k-1]                     = slot_q[k].reg_write;
        assign w_slot_ld[k-1]                     = slot_q[k].is_load;
        assign w_slot_rd[(k-1)*REG_AW +: REG_AW]  = slot_q[k].rd[REG_AW-1:0];
    end

    fwd_select #(
        .PIPE_DEPTH      (PIPE_DEPTH),
        .REG_AW          (REG_AW),
        .LOAD_READY_SLOT (LOAD_READY_SLOT),
        .SEL_W           (SEL_W)
    ) u_fwd_a (
        .rs_i        (slot_q[1].rs1[REG_AW-1:0]),
        .valid_i     (w_slot_valid),
        .reg_write_i (w_slot_wr),
        .is_load_i   (w_slot_ld),
        .rd_i        (w_slot_rd),
        .sel_o       (fwd_sel_a)
    );

    fwd_select #(
        .PIPE_DEPTH      (PIPE_DEPTH),
        .REG_AW          (REG_AW),
        .LOAD_READY_SLOT (LOAD_READY_SLOT),
        .SEL_W           (SEL_W)
    ) u_fwd_b (
        .rs_i        (slot_q[1].rs2[REG_AW-1:0]),
        .valid_i     (w_slot_valid),
        .reg_write_i (w_slot_wr),
        .is_load_i   (w_slot_ld),
        .rd_i        (w_slot_rd),
        .sel_o       (fwd_sel_b)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (f_d_flush && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked
// against an instruction-queue model of the hazard rules.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    localparam int PD  = 3;
    localparam int AW  = 5;
    localparam int LRS = 3;
    localparam int SW  = $clog2(PD);

    logic          clk = 1'b0;
    logic          rst;
    logic          d_valid, d_use_rs1, d_use_rs2, d_reg_write, d_is_load, d_is_long;
    logic [AW-1:0] d_rs1, d_rs2, d_rd;
    logic          e_redirect, lu_done;
    logic          pc_en, f_d_en, d_e_en, f_d_flush, d_e_flush, lu_start;
    logic [SW-1:0] fwd_sel_a, fwd_sel_b;
    logic [31:0]   stall_cycles, flush_count;

    hazard_scoreboard #(
        .PIPE_DEPTH(PD), .REG_AW(AW), .LOAD_READY_SLOT(LRS), .SEL_W(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .d_rd(d_rd), .d_reg_write(d_reg_write), .d_is_load(d_is_load), .d_is_long(d_is_long),
        .e_redirect(e_redirect), .lu_done(lu_done),
        .pc_en(pc_en), .f_d_en(f_d_en), .d_e_en(d_e_en),
        .f_d_flush(f_d_flush), .d_e_flush(d_e_flush), .lu_start(lu_start),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pipe[0] is slot 1 (E), pipe[PD-1] is slot PD (W).
    typedef struct packed {
        bit v; int rd; bit wr; bit ld; bit lg; int rs1; int rs2; bit u1; bit u2;
    } ins_t;

    ins_t          pipe[$];
    bit            m_busy, m_start, m_freeze;
    longint        m_stall, m_flush;
    logic [5:0]    e_ctrl;     // {pc_en, f_d_en, d_e_en, f_d_flush, d_e_flush, lu_start}
    logic [SW-1:0] e_sa, e_sb;

    function automatic void model_reset();
        ins_t bub = '0;
        pipe.delete();
        for (int i = 0; i < PD; i++) pipe.push_back(bub);
        m_busy  = 1'b0;
        m_stall = 0;
        m_flush = 0;
    endfunction

    function automatic ins_t dec_ins();
        ins_t x = '0;
        if (d_valid) begin
            x.v = 1'b1; x.rd = int'(d_rd); x.wr = d_reg_write; x.ld = d_is_load; x.lg = d_is_long;
            x.rs1 = int'(d_rs1); x.rs2 = int'(d_rs2); x.u1 = d_use_rs1; x.u2 = d_use_rs2;
        end
        return x;
    endfunction

    function automatic int fwd_for(int rs);
        for (int k = 2; k <= PD; k++) begin
            ins_t p = pipe[k-1];
            if (p.v && p.wr && p.rd != 0 && p.rd == rs && !(p.ld && k < LRS)) return k - 1;
        end
        return 0;
    endfunction

    function automatic void model_eval();
        ins_t s1;
        bit   lu;
        s1       = pipe[0];
        m_start  = !m_busy && s1.v && s1.lg;
        m_freeze = (m_busy || m_start) && !lu_done;
        lu       = 1'b0;
        if (d_valid) begin
            for (int j = 1; j <= PD; j++) begin
                ins_t p = pipe[j-1];
                int wait_left = LRS - 1 - j;
                if (p.v && p.ld && p.rd != 0 && wait_left > 0
                    && ((d_use_rs1 && int'(d_rs1) == p.rd) || (d_use_rs2 && int'(d_rs2) == p.rd)))
                    lu = 1'b1;
            end
        end
        e_ctrl = {5'b11100, m_start};
        if (m_freeze) e_ctrl[5:3] = 3'b000;
        else if (e_redirect && s1.v && !s1.lg) e_ctrl[2:1] = 2'b11;
        else if (lu) begin e_ctrl[5:4] = 2'b00; e_ctrl[1] = 1'b1; end
        e_sa = SW'(fwd_for(s1.rs1));
        e_sb = SW'(fwd_for(s1.rs2));
    endfunction

    function automatic void model_step();
        ins_t held;
        ins_t bub = '0;
        model_eval();
        if (!e_ctrl[5] && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (e_ctrl[2] && m_flush < 64'hFFFF_FFFF) m_flush++;
        if (m_freeze) begin
            held = pipe.pop_front();
            pipe.push_front(bub);
            pipe.push_front(held);
        end else begin
            pipe.push_front((e_ctrl[3] && !e_ctrl[1]) ? dec_ins() : bub);
        end
        void'(pipe.pop_back());
        if (m_start && !lu_done) m_busy = 1'b1;
        else if (m_busy && lu_done) m_busy = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic set_dec(input bit v, input int rd, input bit wr, input bit ld, input bit lg,
                           input int rs1, input bit u1, input int rs2, input bit u2);
        d_valid = v; d_rd = AW'(rd); d_reg_write = wr; d_is_load = ld; d_is_long = lg;
        d_rs1 = AW'(rs1); d_use_rs1 = u1; d_rs2 = AW'(rs2); d_use_rs2 = u2;
    endtask

    task automatic set_idle();
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_redirect = 1'b0;
        lu_done    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({pc_en, f_d_en, d_e_en, f_d_flush, d_e_flush, lu_start} !== 6'b111000)
            $display("FAIL reset_ctrl: got %b expected 111000",
                     {pc_en, f_d_en, d_e_en, f_d_flush, d_e_flush, lu_start});
        else n_pass++;
        n_total++;
        if ({fwd_sel_a, fwd_sel_b} !== '0)
            $display("FAIL reset_sel: got a=%0d b=%0d expected 0/0", fwd_sel_a, fwd_sel_b);
        else n_pass++;
        n_total++;
        if ({stall_cycles, flush_count} !== 64'd0)
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count);
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_chain();
        set_idle(); repeat (3) tick();
        set_dec(1, 5, 1, 0, 0, 0, 1, 0, 0);            // addi x5, x0, 7
        @(negedge clk);
        n_total++;
        if (pc_en !== 1'b1) $display("FAIL chain_pc_en0: got %b expected 1", pc_en); else n_pass++;
        tick();
        set_dec(1, 6, 1, 0, 0, 5, 1, 5, 1);            // add x6, x5, x5
        @(negedge clk);
        n_total++;
        if (pc_en !== 1'b1) $display("FAIL chain_pc_en1: got %b expected 1", pc_en); else n_pass++;
        tick();
        set_idle();
        @(negedge clk);
        n_total++;
        if (fwd_sel_a !== 2'd1 || fwd_sel_b !== 2'd1)
            $display("FAIL chain_fwd: got a=%0d b=%0d expected 1/1", fwd_sel_a, fwd_sel_b);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        set_idle(); repeat (3) tick();
        set_dec(1, 5, 1, 1, 0, 2, 1, 0, 0);            // lw x5, 0(x2)
        tick();
        set_dec(1, 6, 1, 0, 0, 5, 1, 1, 1);            // add x6, x5, x1
        @(negedge clk);
        n_total++;
        if ({pc_en, f_d_en, d_e_flush} !== 3'b001)
            $display("FAIL lu_stall: got pc/fd/def=%b expected 001", {pc_en, f_d_en, d_e_flush});
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if ({pc_en, d_e_flush} !== 2'b10)
            $display("FAIL lu_release: got pc/def=%b expected 10", {pc_en, d_e_flush});
        else n_pass++;
        tick();
        set_idle();
        @(negedge clk);
        n_total++;
        if (fwd_sel_a !== 2'd2)
            $display("FAIL lu_fwd_a: got %0d expected 2", fwd_sel_a); else n_pass++;
        n_total++;
        if (fwd_sel_b !== 2'd0)
            $display("FAIL lu_fwd_b: got %0d expected 0", fwd_sel_b); else n_pass++;
        tick();
    endtask

    task automatic test_long();
        set_idle(); repeat (3) tick();
        set_dec(1, 7, 1, 0, 1, 1, 1, 2, 1);            // div x7, x1, x2
        tick();
        set_dec(1, 8, 1, 0, 0, 7, 1, 0, 0);            // follower reading x7
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if ({pc_en, f_d_en, d_e_en, lu_start} !== {3'b000, (i == 0)})
                $display("FAIL long_freeze cyc %0d: got pc/fd/de/start=%b expected %b", i,
                         {pc_en, f_d_en, d_e_en, lu_start}, {3'b000, (i == 0)});
            else n_pass++;
            tick();
        end
        lu_done = 1'b1;
        @(negedge clk);
        n_total++;
        if ({pc_en, d_e_en, lu_start} !== 3'b110)
            $display("FAIL long_done: got pc/de/start=%b expected 110", {pc_en, d_e_en, lu_start});
        else n_pass++;
        tick();
        set_idle();
        @(negedge clk);
        n_total++;
        if (fwd_sel_a !== 2'd1 || pc_en !== 1'b1)
            $display("FAIL long_resume: got sel_a=%0d pc=%b expected 1/1", fwd_sel_a, pc_en);
        else n_pass++;
        tick();
    endtask

    task automatic test_redirect();
        set_idle(); repeat (3) tick();
        set_dec(1, 5, 1, 1, 0, 2, 1, 0, 0);            // lw x5
        tick();
        set_dec(1, 6, 1, 0, 0, 5, 1, 1, 1);            // add x6, x5, x1 with redirect
        e_redirect = 1'b1;
        @(negedge clk);
        n_total++;
        if ({pc_en, f_d_flush, d_e_flush} !== 3'b111)
            $display("FAIL redir_win: got pc/fdf/def=%b expected 111", {pc_en, f_d_flush, d_e_flush});
        else n_pass++;
        tick();
        e_redirect = 1'b0;
        @(negedge clk);
        n_total++;
        if ({pc_en, d_e_flush} !== 2'b10)
            $display("FAIL redir_no_stall: got pc/def=%b expected 10", {pc_en, d_e_flush});
        else n_pass++;
        tick();
    endtask

    task automatic test_x0();
        set_idle(); repeat (3) tick();
        set_dec(1, 0, 1, 0, 0, 1, 1, 0, 0);            // addi x0, x1, 1
        tick();
        set_dec(1, 0, 1, 1, 0, 2, 1, 0, 0);            // lw x0
        tick();
        set_dec(1, 3, 1, 0, 0, 0, 1, 0, 1);            // add x3, x0, x0
        @(negedge clk);
        n_total++;
        if (pc_en !== 1'b1) $display("FAIL x0_no_stall: got %b expected 1", pc_en); else n_pass++;
        tick();
        set_idle();
        @(negedge clk);
        n_total++;
        if ({fwd_sel_a, fwd_sel_b} !== '0)
            $display("FAIL x0_fwd: got a=%0d b=%0d expected 0/0", fwd_sel_a, fwd_sel_b);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_busy();
        set_idle(); repeat (3) tick();
        set_dec(1, 9, 1, 0, 1, 1, 1, 0, 0);
        tick();
        set_idle();
        @(negedge clk);
        n_total++;
        if ({lu_start, pc_en} !== 2'b10)
            $display("FAIL rb_start: got start/pc=%b expected 10", {lu_start, pc_en});
        else n_pass++;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({pc_en, f_d_en, d_e_en, f_d_flush, d_e_flush, lu_start} !== 6'b111000)
            $display("FAIL rb_ctrl: got %b expected 111000",
                     {pc_en, f_d_en, d_e_en, f_d_flush, d_e_flush, lu_start});
        else n_pass++;
        n_total++;
        if ({stall_cycles, flush_count} !== 64'd0)
            $display("FAIL rb_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({pc_en, d_e_en, lu_start} !== 3'b110)
            $display("FAIL rb_idle: got pc/de/start=%b expected 110", {pc_en, d_e_en, lu_start});
        else n_pass++;
        tick();
        set_dec(1, 10, 1, 0, 1, 1, 1, 0, 0);
        tick();
        set_idle();
        lu_done = 1'b1;                                 // single-cycle latency: no freeze
        @(negedge clk);
        n_total++;
        if ({lu_start, pc_en, d_e_en} !== 3'b111)
            $display("FAIL rb_restart: got start/pc/de=%b expected 111", {lu_start, pc_en, d_e_en});
        else n_pass++;
        tick();
        lu_done = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            bit lg;
            lg = ($urandom_range(0, 7) == 0);
            set_dec($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                    !lg && ($urandom_range(0, 3) == 0), lg,
                    $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 3), $urandom_range(0, 1));
            e_redirect = ($urandom_range(0, 7) == 0);
            lu_done    = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            model_eval();
            n_total++;
            if ({pc_en, f_d_en, d_e_en, f_d_flush, d_e_flush, lu_start} !== e_ctrl)
                $display("FAIL rand_ctrl cyc %0d: got %b expected %b", c,
                         {pc_en, f_d_en, d_e_en, f_d_flush, d_e_flush, lu_start}, e_ctrl);
            else n_pass++;
            n_total++;
            if (fwd_sel_a !== e_sa || fwd_sel_b !== e_sb)
                $display("FAIL rand_fwd cyc %0d: got a=%0d b=%0d expected %0d/%0d", c,
                         fwd_sel_a, fwd_sel_b, e_sa, e_sb);
            else n_pass++;
            n_total++;
`ifdef HAZARD_PERF_EN
            if (stall_cycles !== 32'(m_stall) || flush_count !== 32'(m_flush))
                $display("FAIL rand_counters cyc %0d: got %0d/%0d expected %0d/%0d", c,
                         stall_cycles, flush_count, m_stall, m_flush);
            else n_pass++;
`else
            if ({stall_cycles, flush_count} !== 64'd0)
                $display("FAIL rand_counters cyc %0d: got %0d/%0d expected 0/0", c,
                         stall_cycles, flush_count);
            else n_pass++;
`endif
            tick();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_chain();
        test_load_use();
        test_long();
        test_redirect();
        test_x0();
        test_reset_busy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed E/M/W hazard unit in the 5-stage RV32I pipeline.
- Keeps its own shadow pipeline of destination and control tags for a configurable number of post-decode slots, so forwarding and stall decisions no longer need opcode taps from every stage.
- Adds a stall handshake for a variable-latency multi-cycle execute unit (MUL/DIV).
- Drives PC/F_D/D_E enables, flushes, and forwarding-mux selects for both execute operands.

Parameters:
- PIPE_DEPTH, 3: post-decode slots tracked. Slot 1 = E, slot PIPE_DEPTH = W. Minimum 2.
- REG_AW, 5: register address width.
- LOAD_READY_SLOT, 3: first slot at which load data can be forwarded. Range 2..PIPE_DEPTH.
- SEL_W, $clog2(PIPE_DEPTH): forwarding select width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- d_valid  in  1  decode holds a real instruction
- d_rs1, d_rs2  in  REG_AW  decode source registers
- d_use_rs1, d_use_rs2  in  1  source is actually read
- d_rd  in  REG_AW  decode destination
- d_reg_write  in  1  decode instruction writes rd
- d_is_load  in  1  decode instruction is a load
- d_is_long  in  1  decode instruction uses the multi-cycle unit
- e_redirect  in  1  slot-1 branch taken or jump
- lu_done  in  1  multi-cycle unit result valid this cycle
- pc_en, f_d_en, d_e_en  out  1  stage enables
- f_d_flush, d_e_flush  out  1  insert bubble into F_D / D_E
- lu_start  out  1  one-cycle start pulse to the multi-cycle unit
- fwd_sel_a, fwd_sel_b  out  SEL_W  0 = register file; k = forward from slot k+1
- stall_cycles, flush_count  out  32  performance counters (see Optional Feature)

Behaviour:
- Slot state per slot: valid, rd, reg_write, is_load, is_long, rs1, rs2, use flags. On rst all slots are invalid and all fields are 0.
- Reset values: pc_en = f_d_en = d_e_en = 1; every other output = 0.
- Advance: when not frozen, slot k+1 <= slot k each cycle. Slot 1 <= decode tags when d_e_en && !d_e_flush; otherwise slot 1 <= bubble.
- Load-use stall: stall when a valid load in slot j has j+1 < LOAD_READY_SLOT and rd != 0 matches a used d_rs*.
  - pc_en = f_d_en = 0 for that cycle.
  - d_e_flush = 1, so slot 1 becomes a bubble.
  - Lasts exactly LOAD_READY_SLOT-1-j cycles. Defaults give 1 cycle.
- Forwarding:
  - For each slot-1 operand, select the smallest k >= 2 with: valid, reg_write, rd != 0, rd == slot-1 rs, and the source not a load below LOAD_READY_SLOT. Output sel = k-1.
  - With no match, output sel = 0.
  - x0 is never forwarded.
  - Purely combinational from slot state.
- Multi-cycle FSM, states IDLE / BUSY:
  - IDLE -> BUSY on the first cycle a valid is_long op is in slot 1. lu_start = 1 for that cycle only.
  - While in BUSY, or on the entry cycle without lu_done:
    - pc_en = f_d_en = d_e_en = 0.
    - Slots 0..1 are frozen.
    - Slot 2 receives bubbles; slots >= 2 keep draining.
  - BUSY -> IDLE on lu_done. Slot 1 advances that same cycle.
  - lu_done arriving in the start cycle means 1-cycle latency and gives no freeze.
  - lu_done while IDLE is ignored.
- Redirect: e_redirect => f_d_flush = d_e_flush = 1 and pc_en = 1.
  - Redirect overrides a load-use stall in the same cycle.
  - Redirect is ignored when slot 1 is invalid.
  - A long op cannot redirect.
- Precedence: rst > long-unit freeze > redirect > load-use stall > normal advance.
- Reset mid-operation: rst during BUSY returns to IDLE, invalidates all slots, and gives no lu_start.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - stall_cycles increments on every cycle with pc_en = 0.
  - flush_count increments on every cycle with f_d_flush = 1.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined: both outputs are tied to 0 and no counter flops are synthesised.

Decomposition:
- Package hazard_pkg holds:
  - slot_t packed struct: valid, rd, reg_write, is_load, is_long, rs1, rs2, use flags.
  - lu_state_e enum: IDLE, BUSY.
  - REG_ZERO constant.
- One sub-module, fwd_select: parametrised priority matcher, instantiated twice (operand a, operand b).

Test Plan:
- Chain: addi x5,x0,7; add x6,x5,x5 with PIPE_DEPTH=3 -> fwd_sel_a = fwd_sel_b = 1 (slot 2) in the add's E cycle; no stall cycles.
- Load-use: lw x5 immediately followed by add x6,x5,x1 with LOAD_READY_SLOT=3 -> exactly one cycle with pc_en = 0 and d_e_flush = 1; then fwd_sel_a = 2 (slot 3, W); fwd_sel_b = 0 (x1 not pending).
- Multi-cycle: div in slot 1, lu_done driven 4 cycles after lu_start -> lu_start high 1 cycle; pc_en/d_e_en low 4 cycles; slot 2 carries 4 bubbles; following instruction resumes next cycle.
- Simultaneous: e_redirect asserted in the same cycle a load-use match is detected -> f_d_flush = d_e_flush = 1, pc_en = 1; no stall cycle follows.
- x0 and reset: writes to x0 in slots 2..3 with a reader of x0 -> sel = 0. Then assert rst during BUSY -> all enables = 1, flushes = 0, FSM IDLE; counters = 0 when HAZARD_PERF_EN is defined.
